lane_unit: RTL and testbench

LANE_UNIT -- requirements
Module: lane_unit

---
 rtl/lane_unit.sv | 184 ++++++++++++++++++
 tb/tb_lane_unit.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/lane_unit.sv
// Single lane unit: spawns on request, advances or attacks on move strobes,
// takes damage, and recycles through a timed DEAD state back to IDLE.
module lane_unit #(
  parameter int POS_W       = 9,
  parameter int DMG_W       = 8,
  parameter int DIR         = 0,
  parameter int START_POS   = (DIR == 0) ? 0 : (2**POS_W - 1),
  parameter int POWER1      = 'h20,
  parameter int POWER2      = 'h40,
  parameter int POWER3      = 'h80,
  parameter int HEALTH1     = 'hFF,
  parameter int HEALTH2     = 'hC0,
  parameter int HEALTH3     = 'h80,
  parameter int DEAD_CYCLES = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             spawn_req,
  input  logic [1:0]       spawn_type,
  output logic             spawn_ack,
  input  logic             move_scen,
  input  logic             damage_scen,
  input  logic [DMG_W-1:0] damage_in,
  input  logic [POS_W-1:0] unit_front,
  output logic [POS_W-1:0] position,
  output logic [DMG_W-1:0] damage_out,
  output logic [1:0]       unit_type,
  output logic [DMG_W-1:0] health,
  output logic             reached_base,
  output logic [3:0]       state_oh
);

  // state  | meaning
  // IDLE   | not fielded, waiting for a typed spawn request
  // DEPLOY | one cycle: load health/power/type, place at spawn point
  // ALIVE  | moving/attacking on move_scen, taking damage on damage_scen
  // DEAD   | dwell of DEAD_CYCLES clocks, all strobes ignored

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DEPLOY = 2'd1,
    S_ALIVE  = 2'd2,
    S_DEAD   = 2'd3
  } state_t;

  localparam int CNT_W = (DEAD_CYCLES < 2) ? 1 : $clog2(DEAD_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DEAD_CYCLES - 1);
  localparam logic [POS_W-1:0] START_P  = POS_W'(START_POS);
  localparam logic [POS_W-1:0] FAR_P    = (DIR == 0) ? '1 : '0;

  state_t           state, state_nxt;
  logic [1:0]       type_lat, type_lat_nxt;
  logic [DMG_W-1:0] power, power_nxt;
  logic [DMG_W-1:0] health_nxt, dmg_out_nxt;
  logic [POS_W-1:0] pos_nxt, step_pos;
  logic [1:0]       unit_type_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             ack_nxt, base_nxt;
  logic             lethal, can_advance;

  function automatic logic [DMG_W-1:0] type_health(input logic [1:0] t);
    case (t)
      2'd1:    type_health = DMG_W'(HEALTH1);
      2'd2:    type_health = DMG_W'(HEALTH2);
      2'd3:    type_health = DMG_W'(HEALTH3);
      default: type_health = '0;
    endcase
  endfunction

  function automatic logic [DMG_W-1:0] type_power(input logic [1:0] t);
    case (t)
      2'd1:    type_power = DMG_W'(POWER1);
      2'd2:    type_power = DMG_W'(POWER2);
      2'd3:    type_power = DMG_W'(POWER3);
      default: type_power = '0;
    endcase
  endfunction

  // Advancing is only allowed strictly toward the front, so step_pos never wraps.
  assign can_advance = (DIR == 0) ? (unit_front > position) : (unit_front < position);
  assign step_pos    = (DIR == 0) ? (position + 1'b1) : (position - 1'b1);
  assign lethal      = damage_scen && (damage_in >= health);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      type_lat     <= '0;
      power        <= '0;
      health       <= '0;
      damage_out   <= '0;
      position     <= START_P;
      unit_type    <= '0;
      cnt          <= '0;
      spawn_ack    <= 1'b0;
      reached_base <= 1'b0;
    end else begin
      state        <= state_nxt;
      type_lat     <= type_lat_nxt;
      power        <= power_nxt;
      health       <= health_nxt;
      damage_out   <= dmg_out_nxt;
      position     <= pos_nxt;
      unit_type    <= unit_type_nxt;
      cnt          <= cnt_nxt;
      spawn_ack    <= ack_nxt;
      reached_base <= base_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    type_lat_nxt  = type_lat;
    power_nxt     = power;
    health_nxt    = health;
    dmg_out_nxt   = damage_out;
    pos_nxt       = position;
    unit_type_nxt = unit_type;
    cnt_nxt       = cnt;
    ack_nxt       = 1'b0;
    base_nxt      = 1'b0;

    case (state)
      S_IDLE: begin
        if (spawn_req && (spawn_type != 2'd0)) begin
          ack_nxt      = 1'b1;
          type_lat_nxt = spawn_type;
          state_nxt    = S_DEPLOY;
        end
      end

      S_DEPLOY: begin
        health_nxt    = type_health(type_lat);
        power_nxt     = type_power(type_lat);
        unit_type_nxt = type_lat;
        pos_nxt       = START_P;
        dmg_out_nxt   = '0;
        state_nxt     = S_ALIVE;
      end

      S_ALIVE: begin
        if (lethal) begin
          // Death takes priority over any coincident move or attack.
          health_nxt    = '0;
          unit_type_nxt = '0;
          dmg_out_nxt   = '0;
          cnt_nxt       = CNT_LOAD;
          state_nxt     = S_DEAD;
        end else begin
          if (damage_scen) begin
            health_nxt = health - damage_in;
          end
          if (move_scen) begin
            if (can_advance) begin
              pos_nxt     = step_pos;
              dmg_out_nxt = '0;
              if (step_pos == FAR_P) begin
                base_nxt      = 1'b1;
                unit_type_nxt = '0;
                cnt_nxt       = CNT_LOAD;
                state_nxt     = S_DEAD;
              end
            end else begin
              dmg_out_nxt = power;
            end
          end
        end
      end

      S_DEAD: begin
        if (cnt == '0) begin
          pos_nxt   = START_P;
          state_nxt = S_IDLE;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end

      default: state_nxt = S_IDLE;
    endcase
  end

  assign state_oh = {state == S_IDLE, state == S_DEPLOY, state == S_ALIVE, state == S_DEAD};

endmodule

// File: tb/tb_lane_unit.sv
// Directed bench for lane_unit: three instances cover DIR=0 default width,
// DIR=0 with a 4-bit lane (far-end reach), and DIR=1.
module tb_lane_unit;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  // instance A: defaults
  logic       a_req, a_move, a_dmg_s, a_ack, a_base;
  logic [1:0] a_type, a_utype;
  logic [7:0] a_dmg_in, a_dout, a_health;
  logic [8:0] a_front, a_pos;
  logic [3:0] a_oh;

  // instance B: POS_W=4
  logic       b_req, b_move, b_dmg_s, b_ack, b_base;
  logic [1:0] b_type, b_utype;
  logic [7:0] b_dmg_in, b_dout, b_health;
  logic [3:0] b_front, b_pos;
  logic [3:0] b_oh;

  // instance C: DIR=1
  logic       c_req, c_move, c_dmg_s, c_ack, c_base;
  logic [1:0] c_type, c_utype;
  logic [7:0] c_dmg_in, c_dout, c_health;
  logic [8:0] c_front, c_pos;
  logic [3:0] c_oh;

  lane_unit u_a (
    .clk(clk), .reset(reset), .spawn_req(a_req), .spawn_type(a_type), .spawn_ack(a_ack),
    .move_scen(a_move), .damage_scen(a_dmg_s), .damage_in(a_dmg_in), .unit_front(a_front),
    .position(a_pos), .damage_out(a_dout), .unit_type(a_utype), .health(a_health),
    .reached_base(a_base), .state_oh(a_oh)
  );

  lane_unit #(.POS_W(4)) u_b (
    .clk(clk), .reset(reset), .spawn_req(b_req), .spawn_type(b_type), .spawn_ack(b_ack),
    .move_scen(b_move), .damage_scen(b_dmg_s), .damage_in(b_dmg_in), .unit_front(b_front),
    .position(b_pos), .damage_out(b_dout), .unit_type(b_utype), .health(b_health),
    .reached_base(b_base), .state_oh(b_oh)
  );

  lane_unit #(.DIR(1)) u_c (
    .clk(clk), .reset(reset), .spawn_req(c_req), .spawn_type(c_type), .spawn_ack(c_ack),
    .move_scen(c_move), .damage_scen(c_dmg_s), .damage_in(c_dmg_in), .unit_front(c_front),
    .position(c_pos), .damage_out(c_dout), .unit_type(c_utype), .health(c_health),
    .reached_base(c_base), .state_oh(c_oh)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [8:0] exp_pos [3];
  logic [7:0] exp_dout[3];

  initial begin
    reset = 1'b1;
    {a_req, a_move, a_dmg_s} = '0; a_type = '0; a_dmg_in = '0; a_front = '0;
    {b_req, b_move, b_dmg_s} = '0; b_type = '0; b_dmg_in = '0; b_front = '0;
    {c_req, c_move, c_dmg_s} = '0; c_type = '0; c_dmg_in = '0; c_front = '0;
    #3;
    check("rst_a_oh", a_oh, 4'b1000);
    check("rst_a_pos", a_pos, 0);
    check("rst_a_health", a_health, 0);
    check("rst_a_utype", a_utype, 0);
    check("rst_a_ack", a_ack, 0);
    check("rst_a_dout", a_dout, 0);
    check("rst_c_pos", c_pos, 511);
    step; step;
    reset = 1'b0;

    // ---- instance A ----
    a_req = 1'b1; a_type = 2'd0;
    step;
    check("a_type0_ack", a_ack, 0);
    check("a_type0_oh", a_oh, 4'b1000);
    a_type = 2'd2;
    step;
    check("a_spawn2_ack", a_ack, 1);
    check("a_spawn2_oh", a_oh, 4'b0100);
    a_req = 1'b0; a_type = 2'd0;
    step;
    check("a_alive_ack", a_ack, 0);
    check("a_alive_oh", a_oh, 4'b0010);
    check("a_alive_utype", a_utype, 2);
    check("a_alive_health", a_health, 8'hC0);

    // exact-health damage is lethal
    a_dmg_s = 1'b1; a_dmg_in = 8'hC0;
    step;
    check("a_kill_oh", a_oh, 4'b0001);
    check("a_kill_health", a_health, 0);
    check("a_kill_utype", a_utype, 0);
    a_dmg_s = 1'b0; a_req = 1'b1; a_type = 2'd1;
    for (int i = 0; i < 9; i++) begin
      step;
      check("a_dead_ack", a_ack, 0);
      check("a_dead_oh", a_oh, 4'b0001);
    end
    step;
    check("a_back_idle_oh", a_oh, 4'b1000);
    check("a_back_idle_ack", a_ack, 0);
    step;
    check("a_respawn_ack", a_ack, 1);
    a_req = 1'b0; a_type = 2'd0;
    step;
    check("a_t1_utype", a_utype, 1);
    check("a_t1_health", a_health, 8'hFF);
    check("a_t1_pos", a_pos, 0);

    a_front = 9'd7; a_move = 1'b1;
    repeat (5) step;
    check("a_pos5", a_pos, 5);
    exp_pos  = '{9'd6, 9'd7, 9'd7};
    exp_dout = '{8'h00, 8'h00, 8'h20};
    for (int i = 0; i < 3; i++) begin
      step;
      check("a_move_pos", a_pos, exp_pos[i]);
      check("a_move_dout", a_dout, exp_dout[i]);
    end
    a_move = 1'b0;
    step;
    check("a_dout_hold", a_dout, 8'h20);
    check("a_pos_hold", a_pos, 7);

    a_dmg_s = 1'b1; a_dmg_in = 8'hFF;
    step;
    check("a_kill2_oh", a_oh, 4'b0001);
    a_dmg_s = 1'b0;
    step; step;
    #2 reset = 1'b1;
    #1;
    check("a_rst_dead_oh", a_oh, 4'b1000);
    check("a_rst_dead_pos", a_pos, 0);
    check("a_rst_dead_ack", a_ack, 0);
    check("a_rst_dead_dout", a_dout, 0);
    check("a_rst_dead_health", a_health, 0);
    #1 reset = 1'b0;

    a_req = 1'b1; a_type = 2'd3;
    step;
    check("a_spawn3_ack", a_ack, 1);
    a_req = 1'b0; a_type = 2'd0;
    step;
    check("a_t3_health", a_health, 8'h80);
    check("a_t3_utype", a_utype, 3);
    a_front = 9'd0; a_dmg_s = 1'b1; a_dmg_in = 8'h30; a_move = 1'b1;
    step;
    check("a_t3_health50", a_health, 8'h50);
    check("a_t3_attack", a_dout, 8'h80);
    check("a_t3_pos", a_pos, 0);
    a_dmg_in = 8'h50;
    step;
    check("a_t3_dead_oh", a_oh, 4'b0001);
    check("a_t3_dead_pos", a_pos, 0);
    check("a_t3_dead_dout", a_dout, 0);
    check("a_t3_dead_health", a_health, 0);
    a_dmg_s = 1'b0; a_move = 1'b0;

    // ---- instance B: far-end reach ----
    b_req = 1'b1; b_type = 2'd1;
    step;
    b_req = 1'b0; b_type = 2'd0;
    step;
    check("b_alive_oh", b_oh, 4'b0010);
    b_front = 4'd15; b_move = 1'b1;
    repeat (14) step;
    check("b_pos14", b_pos, 14);
    check("b_pos14_base", b_base, 0);
    step;
    check("b_pos15", b_pos, 15);
    check("b_base_pulse", b_base, 1);
    check("b_base_oh", b_oh, 4'b0001);
    b_dmg_s = 1'b1; b_dmg_in = 8'hFF;
    step;
    check("b_base_clear", b_base, 0);
    check("b_dead_pos", b_pos, 15);
    repeat (8) step;
    check("b_dead9_oh", b_oh, 4'b0001);
    step;
    check("b_idle_oh", b_oh, 4'b1000);
    check("b_idle_pos", b_pos, 0);
    b_dmg_s = 1'b0;

    b_req = 1'b1; b_type = 2'd2;
    step;
    b_req = 1'b0; b_type = 2'd0;
    step;
    repeat (14) step;
    step;
    check("b_base2_pulse", b_base, 1);
    b_move = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("b_rst_base", b_base, 0);
    check("b_rst_oh", b_oh, 4'b1000);
    check("b_rst_pos", b_pos, 0);
    #1 reset = 1'b0;
    step;
    check("b_after_rst_base", b_base, 0);

    // ---- instance C: downward ----
    check("c_idle_pos", c_pos, 511);
    c_req = 1'b1; c_type = 2'd1;
    step;
    c_req = 1'b0; c_type = 2'd0;
    step;
    check("c_alive_pos", c_pos, 511);
    c_front = 9'd500; c_move = 1'b1;
    step;
    check("c_move_pos", c_pos, 510);
    check("c_move_dout", c_dout, 0);
    c_front = 9'd510;
    step;
    check("c_attack_pos", c_pos, 510);
    check("c_attack_dout", c_dout, 8'h20);
    c_move = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
